mesh_tile_boot_ctrl: RTL and testbench
======================================

Name: mesh_tile_boot_ctrl

Overview:
Parametrised multi-tile boot and end-of-test sequencer for the RedMulE mesh. It replaces static per-tile strapping with a synthesizable controller that, for N_TILES tiles:
- drives tile_enable, boot_addr, mhartid and fetch_enable, with fetch release staggered per tile;
- tracks each tile's core_sleep to detect completion;
- counts run cycles and flags a timeout.
It sits between the mesh top (or the test environment) and the tile array.

Parameters:
N_TILES, 4, number of tiles controlled (1..64)
STAGGER_CYC, 4, cycles between consecutive fetch_enable releases; also the length of ENABLE (>=1)
CNT_W, 32, width of the cycle counter and of the timeout value
HARTID_BASE, 0, mhartid of tile 0; tile i gets HARTID_BASE+i

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  single-cycle start pulse; honoured only in IDLE
clear_i  in  1  return to IDLE from DONE or TIMEOUT
tile_mask_i  in  N_TILES  tiles participating in the run; latched on start
boot_addr_i  in  32  boot address; latched on start
timeout_i  in  CNT_W  run-cycle limit; 0 disables the timeout; latched on start
core_sleep_i  in  N_TILES  per-tile core_sleep
tile_enable_o  out  N_TILES  per-tile enable
fetch_enable_o  out  N_TILES  per-tile fetch enable
boot_addr_o  out  N_TILES*32  per-tile boot address; tile i in slice [32i+:32]
mhartid_o  out  N_TILES*32  per-tile hart id; constant HARTID_BASE+i
busy_o  out  1  state is ENABLE, RELEASE or RUN
done_o  out  1  state is DONE
timeout_o  out  1  state is TIMEOUT
sleep_seen_o  out  N_TILES  sticky per-tile completion bits
cycles_o  out  CNT_W  run-cycle count

Behaviour:
Reset values (asynchronous):
- state=IDLE.
- tile_enable_o, fetch_enable_o, boot_addr_o, sleep_seen_o, cycles_o, busy_o, done_o, timeout_o all 0.
- mhartid_o is never reset; it is a constant.
- Reset mid-run aborts immediately with no handshake.

IDLE:
- start_i=1 in cycle T latches mask, boot_addr and timeout, and clears sleep_seen_o and cycles_o.
- From T+1: state=ENABLE, tile_enable_o=mask, boot_addr_o[i]=boot_addr for masked tiles and 0 for unmasked tiles.
- If the mask is 0, go directly to DONE at T+1 with cycles_o=0.

ENABLE:
- Lasts exactly STAGGER_CYC cycles, then RELEASE with tile index k=0.

RELEASE:
- Scans k from 0 to N_TILES-1.
- If mask[k]=1: set fetch_enable_o[k], then spend STAGGER_CYC cycles on that index before advancing.
- If mask[k]=0: spend 1 cycle on that index, with no output change.
- After index N_TILES-1, go to RUN.
- fetch_enable bits stay set until DONE, TIMEOUT-clear or reset.

Cycle counter:
- cycles_o increments every cycle from the cycle after the first fetch_enable release, through RELEASE and RUN.
- Saturates at all-ones; no wrap.

Completion tracking:
- sleep_seen_o[i] sets when fetch_enable_o[i]=1 and core_sleep_i[i]=1 in the same cycle.
- core_sleep before release is ignored. The bit is sticky.

RUN:
- Done condition: (sleep_seen_o | ~mask) is all-ones.
- If the done condition is met → DONE.
- Else if timeout≠0 and cycles_o ≥ timeout → TIMEOUT.
- If both are true in the same cycle, DONE wins.
- The done condition can only be met in RUN. A tile that completes during RELEASE is recorded, but the state change waits until RUN.

DONE:
- fetch_enable_o and tile_enable_o are cleared in the entry cycle.
- cycles_o, sleep_seen_o and boot_addr_o are held.
- clear_i=1 → IDLE.

TIMEOUT:
- Enables stay asserted so tile state can be inspected.
- cycles_o frozen; sleep_seen_o still updates.
- clear_i=1 → IDLE, with all enables and boot_addr_o cleared.

Input conditions ignored:
- start_i outside IDLE.
- clear_i in IDLE, ENABLE, RELEASE or RUN.
- If start_i and clear_i are high together in DONE, clear_i applies; start_i is not remembered.

Test Plan:
- Reset mid-run: N_TILES=4, mask=4'b1111, STAGGER_CYC=4, start at T → tile_enable=F at T+1; fetch_enable bits rise at T+5, T+9, T+13, T+17; rst_ni low at T+10 → all outputs 0 immediately.
- Sparse mask and skip timing: mask=4'b0101, STAGGER_CYC=4, start at T → fetch[0] at T+5, fetch[2] at T+10 (index 1 costs 1 cycle); boot_addr_o slices 1 and 3 = 0; mhartid_o = {3,2,1,0} with HARTID_BASE=0.
- Completion: mask=4'b0011, core_sleep_i[1] high before its release and core_sleep_i[0] high 50 cycles into RUN → early sleep ignored; DONE only after both are seen post-release; enables drop; cycles_o held; clear_i → IDLE.
- Timeout and override: timeout=100, no sleep → TIMEOUT when cycles_o=100 with enables held; rerun with a tile completing at exactly cycles_o=100 → DONE, not TIMEOUT.
- Empty mask and ignored inputs: mask=0 → DONE at T+1 with cycles_o=0; start_i pulsed during RUN → ignored; timeout=0 with no sleep for 10000 cycles → stays in RUN.
- Saturation: CNT_W=8, timeout=0, no sleep → cycles_o saturates at 255, no wrap, state stays RUN.

Source files
------------

// File: rtl/mesh_tile_boot_ctrl.sv
// rtl/mesh_tile_boot_ctrl.sv - multi-tile boot and end-of-test sequencer for the RedMulE mesh
module mesh_tile_boot_ctrl #(
    parameter int unsigned N_TILES     = 4,
    parameter int unsigned STAGGER_CYC = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned HARTID_BASE = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    clear_i,
    input  logic [N_TILES-1:0]      tile_mask_i,
    input  logic [31:0]             boot_addr_i,
    input  logic [CNT_W-1:0]        timeout_i,
    input  logic [N_TILES-1:0]      core_sleep_i,
    output logic [N_TILES-1:0]      tile_enable_o,
    output logic [N_TILES-1:0]      fetch_enable_o,
    output logic [N_TILES*32-1:0]   boot_addr_o,
    output logic [N_TILES*32-1:0]   mhartid_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    timeout_o,
    output logic [N_TILES-1:0]      sleep_seen_o,
    output logic [CNT_W-1:0]        cycles_o
);

    localparam int unsigned   KW     = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam int unsigned   SW     = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_TILES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(STAGGER_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ENABLE, S_RELEASE, S_RUN, S_DONE, S_TIMEOUT
    } state_t;

    state_t             state_q, state_d;
    logic [N_TILES-1:0] mask_q, tile_en_q, fetch_q, seen_q, seen_d, rel_bit;
    logic [31:0]        addr_q;
    logic               addr_vld_q;
    logic [CNT_W-1:0]   timeout_q, cyc_q;
    logic [KW-1:0]      k_q, k_nxt;
    logic [SW-1:0]      stg_q;
    logic               stg_end, idx_end, all_done, timed_out, counting;

    // Unmasked indices cost a single cycle; masked ones hold for the full stagger.
    assign stg_end   = (stg_q == S_LAST);
    assign idx_end   = !mask_q[k_q] || stg_end;
    assign seen_d    = seen_q | (fetch_q & core_sleep_i);
    assign all_done  = &(seen_d | ~mask_q);
    assign timed_out = (timeout_q != '0) && (cyc_q >= timeout_q);
    assign k_nxt     = (state_q == S_ENABLE) ? '0 : k_q + KW'(1);
    assign rel_bit   = N_TILES'(1) << k_nxt;
    assign counting  = ((state_q == S_RELEASE) || (state_q == S_RUN)) &&
                       ((state_d == S_RELEASE) || (state_d == S_RUN)) && (|fetch_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_i) state_d = (tile_mask_i == '0) ? S_DONE : S_ENABLE;
            S_ENABLE:  if (stg_end) state_d = S_RELEASE;
            S_RELEASE: if (idx_end && (k_q == K_LAST)) state_d = S_RUN;
            S_RUN: begin
                if (all_done)       state_d = S_DONE;
                else if (timed_out) state_d = S_TIMEOUT;
            end
            S_DONE, S_TIMEOUT: if (clear_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (state_q == S_ENABLE) || (state_q == S_RELEASE) || (state_q == S_RUN);
        done_o    = (state_q == S_DONE);
        timeout_o = (state_q == S_TIMEOUT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q     <= '0;
            tile_en_q  <= '0;
            fetch_q    <= '0;
            seen_q     <= '0;
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
            timeout_q  <= '0;
            cyc_q      <= '0;
            k_q        <= '0;
            stg_q      <= '0;
        end else begin
            seen_q <= seen_d;
            if (counting && (cyc_q != '1)) cyc_q <= cyc_q + CNT_W'(1);
            case (state_q)
                S_IDLE: if (start_i) begin
                    mask_q     <= tile_mask_i;
                    tile_en_q  <= tile_mask_i;
                    addr_q     <= boot_addr_i;
                    addr_vld_q <= 1'b1;
                    timeout_q  <= timeout_i;
                    seen_q     <= '0;
                    cyc_q      <= '0;
                    stg_q      <= '0;
                    k_q        <= '0;
                end
                S_ENABLE: begin
                    stg_q <= stg_end ? '0 : stg_q + SW'(1);
                    if (stg_end) begin
                        k_q     <= '0;
                        fetch_q <= fetch_q | (mask_q & rel_bit);
                    end
                end
                S_RELEASE: begin
                    if (idx_end) begin
                        stg_q <= '0;
                        if (k_q != K_LAST) begin
                            k_q     <= k_nxt;
                            fetch_q <= fetch_q | (mask_q & rel_bit);
                        end
                    end else begin
                        stg_q <= stg_q + SW'(1);
                    end
                end
                S_RUN: if (state_d == S_DONE) begin
                    fetch_q   <= '0;
                    tile_en_q <= '0;
                end
                S_DONE, S_TIMEOUT: if (clear_i) begin
                    fetch_q    <= '0;
                    tile_en_q  <= '0;
                    addr_vld_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign tile_enable_o  = tile_en_q;
    assign fetch_enable_o = fetch_q;
    assign sleep_seen_o   = seen_q;
    assign cycles_o       = cyc_q;

    for (genvar i = 0; i < N_TILES; i++) begin : g_tile
        assign boot_addr_o[32*i +: 32] = (addr_vld_q && mask_q[i]) ? addr_q : 32'd0;
        assign mhartid_o[32*i +: 32]   = HARTID_BASE + 32'(i);
    end

endmodule

// File: tb/tb_mesh_tile_boot_ctrl.sv
// tb/tb_mesh_tile_boot_ctrl.sv - self-checking bench for mesh_tile_boot_ctrl
module tb_mesh_tile_boot_ctrl;
    localparam int S  = 4;
    localparam int NV = 1000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_ni, start_i, clear_i;
    logic [3:0]   tile_mask_i, core_sleep_i;
    logic [31:0]  boot_addr_i, timeout_i;
    logic [3:0]   tile_enable_o, fetch_enable_o, sleep_seen_o;
    logic [127:0] boot_addr_o, mhartid_o;
    logic         busy_o, done_o, timeout_o;
    logic [31:0]  cycles_o;

    logic         s8_start, s8_clear;
    logic [3:0]   s8_mask, s8_sleep, s8_ten, s8_fen, s8_seen;
    logic [7:0]   s8_to, s8_cyc;
    logic [127:0] s8_baddr, s8_hart;
    logic         s8_busy, s8_done, s8_tmo;

    mesh_tile_boot_ctrl #(.N_TILES(4), .STAGGER_CYC(S), .CNT_W(32), .HARTID_BASE(0)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .clear_i(clear_i),
        .tile_mask_i(tile_mask_i), .boot_addr_i(boot_addr_i), .timeout_i(timeout_i),
        .core_sleep_i(core_sleep_i), .tile_enable_o(tile_enable_o),
        .fetch_enable_o(fetch_enable_o), .boot_addr_o(boot_addr_o), .mhartid_o(mhartid_o),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
        .sleep_seen_o(sleep_seen_o), .cycles_o(cycles_o)
    );

    mesh_tile_boot_ctrl #(.N_TILES(4), .STAGGER_CYC(S), .CNT_W(8), .HARTID_BASE(0)) dut8 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(s8_start), .clear_i(s8_clear),
        .tile_mask_i(s8_mask), .boot_addr_i(boot_addr_i), .timeout_i(s8_to),
        .core_sleep_i(s8_sleep), .tile_enable_o(s8_ten),
        .fetch_enable_o(s8_fen), .boot_addr_o(s8_baddr), .mhartid_o(s8_hart),
        .busy_o(s8_busy), .done_o(s8_done), .timeout_o(s8_tmo),
        .sleep_seen_o(s8_seen), .cycles_o(s8_cyc)
    );

    typedef struct packed {
        logic [3:0] mask;
        int         to;
        int         sa0, sa1, sa2, sa3;
        int         poke_s, poke_c, rst_at, cap;
        int         exp_end;
        bit         exp_done;
        int         exp_cyc;
        logic [3:0] exp_seen;
    } vec_t;

    vec_t tbl[11];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: release times and end time derived from the sequencing rules.
    logic [3:0]  m_mask;
    logic [31:0] m_addr;
    int          m_to, m_run, m_first, m_end;
    bit          m_done;
    int          m_sa[4];
    int          m_rel[4];

    function automatic vec_t mk(input logic [3:0] mask, input int to, input int a0, input int a1,
                                input int a2, input int a3, input int ps, input int pc,
                                input int ra, input int cap, input int ee, input bit ed,
                                input int ec, input logic [3:0] es);
        vec_t v;
        v.mask = mask; v.to = to; v.sa0 = a0; v.sa1 = a1; v.sa2 = a2; v.sa3 = a3;
        v.poke_s = ps; v.poke_c = pc; v.rst_at = ra; v.cap = cap;
        v.exp_end = ee; v.exp_done = ed; v.exp_cyc = ec; v.exp_seen = es;
        return v;
    endfunction

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_build(input int cap);
        int t;
        t = 1 + S;
        m_first = NV;
        for (int k = 0; k < 4; k++) begin
            if (m_mask[k]) begin
                m_rel[k] = t;
                if (t < m_first) m_first = t;
                t += S;
            end else begin
                m_rel[k] = NV;
                t += 1;
            end
        end
        m_run = t; m_end = 0; m_done = 1'b0;
        if (m_mask == 4'h0) begin
            m_end = 1; m_done = 1'b1;
            return;
        end
        for (int tt = m_run; tt <= cap; tt++) begin
            bit dn;
            dn = 1'b1;
            for (int k = 0; k < 4; k++)
                if (m_mask[k] && tt < mx(m_rel[k], m_sa[k])) dn = 1'b0;
            if (dn) begin
                m_end = tt + 1; m_done = 1'b1; break;
            end else if (m_to != 0 && tt - m_first >= m_to) begin
                m_end = tt + 1; m_done = 1'b0; break;
            end
        end
    endtask

    function automatic bit ended(input int t);
        return (m_end > 0) && (t >= m_end);
    endfunction

    task automatic check_cycle(input int t);
        int         e, lim;
        logic [3:0] f, s;
        e   = ended(t) ? m_end - 1 : t;
        lim = (ended(t) && m_done) ? m_end : t;
        for (int k = 0; k < 4; k++) begin
            f[k] = m_mask[k] && (t >= m_rel[k]) && !(ended(t) && m_done);
            s[k] = m_mask[k] && (lim > mx(m_rel[k], m_sa[k]));
        end
        chk($sformatf("fetch t=%0d", t), fetch_enable_o, f);
        chk($sformatf("tile_en t=%0d", t), tile_enable_o, (ended(t) && m_done) ? 4'h0 : m_mask);
        chk($sformatf("seen t=%0d", t), sleep_seen_o, s);
        chk($sformatf("cycles t=%0d", t), cycles_o, (e >= m_first) ? e - m_first : 0);
        chk($sformatf("busy t=%0d", t), busy_o, !ended(t));
        chk($sformatf("done t=%0d", t), done_o, ended(t) && m_done);
        chk($sformatf("timeout t=%0d", t), timeout_o, ended(t) && !m_done);
        for (int i = 0; i < 4; i++)
            chk($sformatf("boot_addr[%0d] t=%0d", i, t), boot_addr_o[32*i +: 32],
                m_mask[i] ? m_addr : 32'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " busy"}, busy_o, 1'b0);
        chk({tag, " done"}, done_o, 1'b0);
        chk({tag, " timeout"}, timeout_o, 1'b0);
        chk({tag, " fetch"}, fetch_enable_o, 4'h0);
        chk({tag, " tile_en"}, tile_enable_o, 4'h0);
        chk({tag, " boot_addr"}, boot_addr_o[127:64] | boot_addr_o[63:0], 64'h0);
    endtask

    task automatic check_reset();
        check_idle("reset");
        chk("reset seen", sleep_seen_o, 4'h0);
        chk("reset cycles", cycles_o, 32'h0);
    endtask

    task automatic run_scn(input vec_t v, input bit also_start);
        int last;
        m_mask = v.mask; m_to = v.to; m_addr = $urandom;
        m_sa[0] = v.sa0; m_sa[1] = v.sa1; m_sa[2] = v.sa2; m_sa[3] = v.sa3;
        model_build(v.cap);
        last = (m_end > 0) ? m_end + 10 : v.cap;
        start_i = 1'b1; clear_i = 1'b0; tile_mask_i = v.mask;
        boot_addr_i = m_addr; timeout_i = v.to; core_sleep_i = 4'h0;
        @(posedge clk); #1;
        for (int t = 1; t <= last; t++) begin
            if (t == v.rst_at) break;
            start_i = (t == v.poke_s);
            clear_i = (t == v.poke_c);
            tile_mask_i = 4'($urandom); boot_addr_i = $urandom; timeout_i = $urandom_range(0, 5);
            for (int k = 0; k < 4; k++) core_sleep_i[k] = (t >= m_sa[k]);
            check_cycle(t);
            if (v.exp_end > 0 && t == v.exp_end - 1) chk("tbl busy before end", busy_o, 1'b1);
            if (v.exp_end > 0 && t == v.exp_end) begin
                chk("tbl done", done_o, v.exp_done);
                chk("tbl timeout", timeout_o, !v.exp_done);
                chk("tbl cycles", cycles_o, v.exp_cyc);
                chk("tbl seen", sleep_seen_o, v.exp_seen);
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0; clear_i = 1'b0; core_sleep_i = 4'h0;
        if (m_end > 0 && v.rst_at == 0) begin
            clear_i = 1'b1; start_i = also_start;
            @(posedge clk); #1;
            clear_i = 1'b0; start_i = 1'b0;
            check_idle("after clear");
            @(posedge clk); #1;
            check_idle("idle hold");
        end else begin
            rst_ni = 1'b0; #1;
            check_reset();
            @(posedge clk); #1;
            rst_ni = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r;
        rst_ni = 1'b0; start_i = 1'b0; clear_i = 1'b0; tile_mask_i = 4'h0;
        boot_addr_i = 32'h0; timeout_i = 32'h0; core_sleep_i = 4'h0;
        s8_start = 1'b0; s8_clear = 1'b0; s8_mask = 4'h0; s8_sleep = 4'h0; s8_to = 8'h0;

        tbl[0]  = mk(4'hF, 0,   30, 30, 30, 30, 25, 0,  0,  200,   31,  1'b1, 25,  4'hF);
        tbl[1]  = mk(4'h5, 0,   25, NV, 40, NV, 0,  20, 0,  200,   41,  1'b1, 35,  4'h5);
        tbl[2]  = mk(4'h3, 100, NV, NV, NV, NV, 0,  0,  0,  300,   106, 1'b0, 100, 4'h0);
        tbl[3]  = mk(4'h3, 100, 20, 105, NV, NV, 50, 0, 0,  300,   106, 1'b1, 100, 4'h3);
        tbl[4]  = mk(4'h0, 0,   NV, NV, NV, NV, 0,  0,  0,  50,    1,   1'b1, 0,   4'h0);
        tbl[5]  = mk(4'h8, 10,  NV, NV, NV, NV, 0,  0,  0,  100,   19,  1'b0, 10,  4'h0);
        tbl[6]  = mk(4'h2, 3,   NV, NV, NV, NV, 0,  0,  0,  100,   13,  1'b0, 6,   4'h0);
        tbl[7]  = mk(4'h3, 0,   65, 1,  NV, NV, 0,  0,  0,  200,   66,  1'b1, 60,  4'h3);
        tbl[8]  = mk(4'hF, 0,   NV, NV, NV, NV, 0,  0,  10, 200,   0,   1'b0, 0,   4'h0);
        tbl[9]  = mk(4'h3, 30,  NV, 45, NV, NV, 0,  0,  0,  200,   36,  1'b0, 30,  4'h0);
        tbl[10] = mk(4'h1, 0,   NV, NV, NV, NV, 500, 0, 0,  10000, 0,   1'b0, 0,   4'h0);

        #1;
        check_reset();
        for (int i = 0; i < 4; i++)
            chk($sformatf("mhartid[%0d]", i), mhartid_o[32*i +: 32], i);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_scn(tbl[i], 1'(i & 1));

        for (int n = 0; n < 30; n++) begin
            r.mask   = 4'($urandom);
            r.to     = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 60);
            r.sa0    = ($urandom_range(0, 3) == 0) ? NV : $urandom_range(1, 60);
            r.sa1    = ($urandom_range(0, 3) == 0) ? NV : $urandom_range(1, 60);
            r.sa2    = ($urandom_range(0, 3) == 0) ? NV : $urandom_range(1, 60);
            r.sa3    = ($urandom_range(0, 3) == 0) ? NV : $urandom_range(1, 60);
            r.poke_s = $urandom_range(2, 40);
            r.poke_c = (r.mask == 4'h0) ? 0 : $urandom_range(2, 12);
            r.rst_at = 0; r.cap = 200;
            r.exp_end = 0; r.exp_done = 1'b0; r.exp_cyc = 0; r.exp_seen = 4'h0;
            run_scn(r, 1'(n & 1));
        end

        s8_start = 1'b1; s8_mask = 4'h1; s8_to = 8'h0;
        @(posedge clk); #1;
        s8_start = 1'b0;
        for (int t = 1; t <= 300; t++) begin
            chk($sformatf("sat cycles t=%0d", t), s8_cyc, (t - 5 > 255) ? 255 : ((t > 5) ? t - 5 : 0));
            @(posedge clk); #1;
        end
        chk("sat busy", s8_busy, 1'b1);
        chk("sat no done", s8_done | s8_tmo, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
